// File: rtl/nios2_sysid_ext.sv
// nios2_sysid_ext: Avalon-MM system ID slave with scratch, status, capability word and a
// fixed-latency read pipeline. Define SYSID_UPTIME_EN to build the 64-bit uptime counter.
module nios2_sysid_ext #(
   parameter logic [31:0] SYSTEM_ID    = 32'hCAFE0001,
   parameter logic [31:0] TIMESTAMP    = 32'd1588802763,
   parameter logic [31:0] CONFIG_WORD  = 32'h00000000,
   parameter int          ADDR_W       = 3,
   parameter int          READ_LATENCY = 1,
   parameter int          UPTIME_DIV   = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              readdatavalid
);

   typedef enum logic [2:0] {
      W_ID        = 3'd0,
      W_TIMESTAMP = 3'd1,
      W_CONFIG    = 3'd2,
      W_SCRATCH   = 3'd3,
      W_UPTIME_LO = 3'd4,
      W_UPTIME_HI = 3'd5,
      W_CAPS      = 3'd6,
      W_STATUS    = 3'd7
   } word_e;

   if (ADDR_W < 3 || ADDR_W > 8 || READ_LATENCY < 1 || READ_LATENCY > 4 ||
       UPTIME_DIV < 1 || UPTIME_DIV > 65535) begin : g_param_check
      $error("nios2_sysid_ext: parameter out of range");
   end

`ifdef SYSID_UPTIME_EN
   localparam logic UPTIME_BIT = 1'b1;
`else
   localparam logic UPTIME_BIT = 1'b0;
`endif

   localparam logic [31:0] CAPS = {20'd0, 8'(ADDR_W), UPTIME_BIT, 3'(READ_LATENCY)};

   // ---------------------------------------------------------------- decode
   logic [7:0]  addr_ext;
   logic        in_map;
   word_e       word;
   logic        rd_uptime_lo;

   assign addr_ext     = 8'(address);
   assign in_map       = (addr_ext[7:3] == 5'd0);
   assign word         = word_e'(addr_ext[2:0]);
   assign rd_uptime_lo = read && in_map && (word == W_UPTIME_LO);

   // ---------------------------------------------------------------- writes
   logic        wr_legal;
   logic        wr_scratch;
   logic        wr_clear;
   logic        wr_bad;
   logic [31:0] scratch;
   logic        wr_err;

   // A write that shares its cycle with a read is dropped and flagged as an error.
   assign wr_legal   = write && !read && in_map && (word == W_SCRATCH || word == W_STATUS);
   assign wr_scratch = wr_legal && (word == W_SCRATCH);
   assign wr_clear   = wr_legal && (word == W_STATUS) && writedata[0];
   assign wr_bad     = write && !wr_legal;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of the order the always_ff blocks are evaluated.
   always_ff @(posedge clock) begin
      if (reset) begin
         scratch <= '0;
         wr_err  <= 1'b0;
      end else begin
         if (wr_scratch) scratch <= writedata;
         if (wr_bad)        wr_err <= 1'b1;
         else if (wr_clear) wr_err <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- uptime
   logic [31:0] uptime_lo;
   logic [31:0] uptime_hi;

`ifdef SYSID_UPTIME_EN
   localparam logic [15:0] DIV_LAST = 16'(UPTIME_DIV - 1);

   logic [15:0] presc;
   logic [63:0] uptime_cnt;
   logic [31:0] uptime_shadow;

   always_ff @(posedge clock) begin
      if (reset) begin
         presc         <= '0;
         uptime_cnt    <= '0;
         uptime_shadow <= '0;
      end else begin
         if (presc == DIV_LAST) begin
            presc      <= '0;
            uptime_cnt <= uptime_cnt + 64'd1;
         end else begin
            presc <= presc + 16'd1;
         end
         // High word is frozen at the moment software reads the low word.
         if (rd_uptime_lo) uptime_shadow <= uptime_cnt[63:32];
      end
   end

   assign uptime_lo = uptime_cnt[31:0];
   assign uptime_hi = uptime_shadow;
`else
   logic unused_uptime;

   assign unused_uptime = rd_uptime_lo;
   assign uptime_lo     = '0;
   assign uptime_hi     = '0;
`endif

   // ---------------------------------------------------------------- read mux
   logic [31:0] rd_value;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      rd_value = '0;
      if (in_map) begin
         case (word)
            W_ID:        rd_value = SYSTEM_ID;
            W_TIMESTAMP: rd_value = TIMESTAMP;
            W_CONFIG:    rd_value = CONFIG_WORD;
            W_SCRATCH:   rd_value = scratch;
            W_UPTIME_LO: rd_value = uptime_lo;
            W_UPTIME_HI: rd_value = uptime_hi;
            W_CAPS:      rd_value = CAPS;
            W_STATUS:    rd_value = {31'd0, wr_err};
            default:     rd_value = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------- read pipeline
   logic [READ_LATENCY-1:0] pipe_vld;
   logic [31:0]             pipe_data [READ_LATENCY];

   // NOTE: the data stages are reset too, because readdata must read 0 whenever
   // readdatavalid is low, including right after reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         pipe_vld <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
      end else begin
         pipe_vld[0]  <= read;
         pipe_data[0] <= read ? rd_value : 32'd0;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_data[i] <= pipe_data[i-1];
         end
      end
   end

   assign readdatavalid = pipe_vld[READ_LATENCY-1];
   assign readdata      = pipe_data[READ_LATENCY-1];

endmodule

// File: tb/tb_nios2_sysid_ext.sv
// tb_nios2_sysid_ext: three instances (latency 1/2/4) driven from a vector table plus
// hand sequences; a scoreboard queue checks every response for data and exact latency.
module tb_nios2_sysid_ext;

   localparam logic [31:0] TS = 32'd1588802763;
`ifdef SYSID_UPTIME_EN
   localparam logic [31:0] UPB = 32'h0000_0008;
`else
   localparam logic [31:0] UPB = 32'h0000_0000;
`endif

   typedef struct {
      int          d;
      logic        r;
      logic        w;
      int          a;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      int          d;
      logic [31:0] data;
      int          due;
   } sb_t;

   logic        clock;
   logic        reset;
   logic        rd    [3];
   logic        wr    [3];
   logic [7:0]  addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic        rvld  [3];

   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   sb_t  sb[$];
   vec_t vt[$];

   nios2_sysid_ext u_a (
      .clock(clock), .reset(reset), .address(addr[0][2:0]), .read(rd[0]), .write(wr[0]),
      .writedata(wdata[0]), .readdata(rdata[0]), .readdatavalid(rvld[0])
   );

   nios2_sysid_ext #(.READ_LATENCY(2), .ADDR_W(4)) u_b (
      .clock(clock), .reset(reset), .address(addr[1][3:0]), .read(rd[1]), .write(wr[1]),
      .writedata(wdata[1]), .readdata(rdata[1]), .readdatavalid(rvld[1])
   );

   nios2_sysid_ext #(.READ_LATENCY(4), .UPTIME_DIV(3)) u_c (
      .clock(clock), .reset(reset), .address(addr[2][2:0]), .read(rd[2]), .write(wr[2]),
      .writedata(wdata[2]), .readdata(rdata[2]), .readdatavalid(rvld[2])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic int rl_of(input int d);
      case (d)
         0:       return 1;
         1:       return 2;
         default: return 4;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drives one cycle of stimulus for instance d (others idle) and records the expectation.
   task automatic apply(input logic rst, input int d, input logic r, input logic w,
                        input int a, input logic [31:0] wd, input logic [31:0] exp);
      for (int k = 0; k < 3; k++) begin
         rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      end
      reset    = rst;
      rd[d]    = r;
      wr[d]    = w;
      addr[d]  = 8'(a);
      wdata[d] = wd;
      if (rst) begin
         for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].due > cyc) sb.delete(i);
      end else if (r) begin
         sb.push_back('{d: d, data: exp, due: cyc + rl_of(d)});
      end
   endtask

   task automatic bus(input logic rst, input int d, input logic r, input logic w,
                      input int a, input logic [31:0] wd, input logic [31:0] exp);
      @(posedge clock);
      #1;
      apply(rst, d, r, w, a, wd, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) bus(1'b0, 0, 1'b0, 1'b0, 0, 32'd0, 32'd0);
   endtask

   task automatic add(input int d, input logic r, input logic w, input int a,
                      input logic [31:0] wd, input logic [31:0] exp);
      vec_t v;
      v.d = d; v.r = r; v.w = w; v.a = a; v.wd = wd; v.exp = exp;
      vt.push_back(v);
   endtask

   // Monitor: every pulse must match the oldest pending read of that instance at its due cycle.
   always @(negedge clock) begin
      int idx;
      for (int d = 0; d < 3; d++) begin
         idx = -1;
         for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].d == d) begin
               idx = i;
               break;
            end
         end
         if (rvld[d] === 1'b1) begin
            if (idx < 0) begin
               check("spurious_valid", 32'(rvld[d]), 32'd0);
            end else begin
               check("read_data", rdata[d], sb[idx].data);
               check("read_latency", 32'(cyc), 32'(sb[idx].due));
               sb.delete(idx);
            end
         end else begin
            check("idle_data_zero", rdata[d], 32'd0);
            if (idx >= 0 && sb[idx].due <= cyc) begin
               check("missing_valid", 32'(rvld[d]), 32'd1);
               sb.delete(idx);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      end

      // instance 0: status semantics
      add(0, 1, 0, 7, 32'h0, 32'h0);
      add(0, 0, 1, 0, 32'h1, 32'h0);
      add(0, 1, 0, 7, 32'h0, 32'h1);
      add(0, 0, 1, 7, 32'h0, 32'h0);
      add(0, 1, 0, 7, 32'h0, 32'h1);
      add(0, 0, 1, 7, 32'h1, 32'h0);
      add(0, 1, 0, 7, 32'h0, 32'h0);
      add(0, 1, 1, 3, 32'h1234, 32'h0);
      add(0, 1, 0, 7, 32'h0, 32'h1);
      add(0, 1, 1, 7, 32'h1, 32'h1);
      add(0, 1, 0, 7, 32'h0, 32'h1);
      add(0, 0, 1, 7, 32'h1, 32'h0);
      add(0, 1, 0, 3, 32'h0, 32'h0);
      add(0, 1, 0, 7, 32'h0, 32'h0);
      add(0, 1, 0, 6, 32'h0, 32'h31 | UPB);
      // instance 1: back-to-back ID reads, scratch, out-of-map words
      add(1, 1, 0, 0, 32'h0, 32'hCAFE0001);
      add(1, 1, 0, 1, 32'h0, TS);
      add(1, 1, 0, 2, 32'h0, 32'h0);
      add(1, 0, 1, 3, 32'hA5A5_5A5A, 32'h0);
      add(1, 1, 0, 3, 32'h0, 32'hA5A5_5A5A);
      add(1, 1, 0, 6, 32'h0, 32'h42 | UPB);
      add(1, 0, 1, 9, 32'hFFFF_FFFF, 32'h0);
      add(1, 1, 0, 7, 32'h0, 32'h1);
      add(1, 1, 0, 12, 32'h0, 32'h0);
      add(1, 0, 1, 7, 32'h1, 32'h0);
      add(1, 1, 0, 7, 32'h0, 32'h0);
      add(1, 0, 1, 6, 32'h0, 32'h0);
      add(1, 1, 0, 7, 32'h0, 32'h1);
      add(1, 0, 1, 7, 32'h1, 32'h0);
      add(1, 0, 1, 5, 32'h0, 32'h0);
      add(1, 1, 0, 7, 32'h0, 32'h1);
      add(1, 0, 1, 7, 32'h1, 32'h0);
      add(1, 1, 0, 7, 32'h0, 32'h0);
      // instance 2: latency 4 with interleaved traffic
      add(2, 1, 0, 6, 32'h0, 32'h34 | UPB);
      add(2, 1, 0, 3, 32'h0, 32'h0);
      add(2, 0, 1, 3, 32'hDEAD_BEEF, 32'h0);
      add(2, 1, 0, 0, 32'h0, 32'hCAFE0001);
      add(2, 1, 0, 3, 32'h0, 32'hDEAD_BEEF);
      add(2, 1, 0, 7, 32'h0, 32'h0);
      add(2, 0, 1, 4, 32'h0, 32'h0);
      add(2, 1, 0, 7, 32'h0, 32'h1);
      add(2, 0, 1, 7, 32'h1, 32'h0);
      add(2, 1, 0, 7, 32'h0, 32'h0);
`ifndef SYSID_UPTIME_EN
      add(0, 1, 0, 4, 32'h0, 32'h0);
      add(0, 1, 0, 5, 32'h0, 32'h0);
      add(0, 0, 1, 5, 32'h0, 32'h0);
      add(0, 1, 0, 7, 32'h0, 32'h1);
      add(0, 0, 1, 7, 32'h1, 32'h0);
      add(0, 1, 0, 7, 32'h0, 32'h0);
`endif
      add(0, 0, 1, 2, 32'h0, 32'h0);

      bus(1'b1, 0, 1'b0, 1'b0, 0, 32'd0, 32'd0);
      bus(1'b1, 0, 1'b0, 1'b0, 0, 32'd0, 32'd0);
      idle(2);
      for (int i = 0; i < vt.size(); i++)
         bus(1'b0, vt[i].d, vt[i].r, vt[i].w, vt[i].a, vt[i].wd, vt[i].exp);
      idle(6);

      // Reset clears scratch and the sticky error in every instance.
      bus(1'b1, 0, 1'b0, 1'b0, 0, 32'd0, 32'd0);
      bus(1'b0, 1, 1'b1, 1'b0, 3, 32'd0, 32'd0);
      bus(1'b0, 2, 1'b1, 1'b0, 3, 32'd0, 32'd0);
      bus(1'b0, 0, 1'b1, 1'b0, 7, 32'd0, 32'd0);
      idle(6);

      // Reset while three reads are in flight, plus a read presented during reset.
      bus(1'b0, 2, 1'b1, 1'b0, 0, 32'd0, 32'hCAFE0001);
      bus(1'b0, 2, 1'b1, 1'b0, 1, 32'd0, TS);
      bus(1'b0, 2, 1'b1, 1'b0, 2, 32'd0, 32'd0);
      bus(1'b1, 2, 1'b1, 1'b0, 0, 32'd0, 32'hCAFE0001);
      idle(8);
      bus(1'b0, 2, 1'b1, 1'b0, 0, 32'd0, 32'hCAFE0001);
      idle(6);

`ifdef SYSID_UPTIME_EN
      // Snapshot: the high word is captured by the low-word read, not read live.
      bus(1'b0, 0, 1'b1, 1'b0, 5, 32'd0, 32'd0);
      @(posedge clock);
      #1;
      force u_a.uptime_cnt = 64'h0000_0001_FFFF_FFFF;
      #1;
      release u_a.uptime_cnt;
      apply(1'b0, 0, 1'b1, 1'b0, 4, 32'd0, 32'hFFFF_FFFF);
      idle(1);
      bus(1'b0, 0, 1'b1, 1'b0, 5, 32'd0, 32'h0000_0001);
      idle(4);
`endif

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
